// File: rtl/stop_idle_rx.sv
// Serial comma-aligned receiver: hunts for COMMA bit-wise, confirms alignment
// over LOCK_COUNT consecutive commas, then delivers non-comma bytes.
module stop_idle_rx #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BIT_W  = 3;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] LOCK_VAL = CNT_W'(LOCK_COUNT);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNC   = 2'd1,
    ST_ACTIVE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [BYTE_W-1:0]   sr_q;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]    bc_cnt_q, bc_cnt_d;
  logic [BIT_W-1:0]    fill_q;
  logic [BYTE_W-1:0]   data_out_d;
  logic                valid_out_d;
  logic                active_d;

  logic [BYTE_W-1:0]   byte_c;
  logic                comma_c;
  logic                boundary_c;
  logic                primed_c;
  logic [CNT_W-1:0]    bc_inc_c;
  logic                sr_msb_unused;

  // Byte assembled at this edge, and the qualifiers derived from it
  assign byte_c        = {sr_q[BYTE_W-2:0], data_in};
  assign comma_c       = (byte_c == COMMA);
  assign boundary_c    = (bit_cnt_q == BIT_W'(7));
  // Ignore the reset zeros in sr until seven real bits have been shifted in
  assign primed_c      = (fill_q == BIT_W'(7));
  assign bc_inc_c      = bc_cnt_q + CNT_W'(1);
  // sr[7] is shifted out and never consumed
  assign sr_msb_unused = sr_q[BYTE_W-1];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_HUNT;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_HUNT: begin
        if (primed_c && comma_c)
          state_d = (LOCK_VAL == CNT_W'(1)) ? ST_ACTIVE : ST_SYNC;
      end
      ST_SYNC: begin
        if (boundary_c) begin
          if (!comma_c)                  state_d = ST_HUNT;
          else if (bc_inc_c == LOCK_VAL) state_d = ST_ACTIVE;
        end
      end
      ST_ACTIVE: state_d = ST_ACTIVE;
      default:   state_d = ST_HUNT;
    endcase
  end

  // Counter and output next values
  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    bc_cnt_d    = bc_cnt_q;
    data_out_d  = data_out;
    valid_out_d = 1'b0;
    active_d    = active;
    case (state_q)
      ST_HUNT: begin
        bit_cnt_d = BIT_W'(0);
        if (primed_c && comma_c) begin
          bc_cnt_d = CNT_W'(1);
          if (LOCK_VAL == CNT_W'(1)) active_d = 1'b1;
        end
      end
      ST_SYNC: begin
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (boundary_c) begin
          if (comma_c) begin
            bc_cnt_d = bc_inc_c;
            if (bc_inc_c == LOCK_VAL) active_d = 1'b1;
          end else begin
            bc_cnt_d = CNT_W'(0);
          end
        end
      end
      ST_ACTIVE: begin
        bit_cnt_d = bit_cnt_q + BIT_W'(1);
        if (boundary_c && !comma_c) begin
          data_out_d  = byte_c;
          valid_out_d = 1'b1;
        end
      end
      default: begin
        bit_cnt_d = BIT_W'(0);
        bc_cnt_d  = CNT_W'(0);
      end
    endcase
  end

  // Shift register, counters and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q      <= '0;
      fill_q    <= '0;
      bit_cnt_q <= '0;
      bc_cnt_q  <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      sr_q      <= byte_c;
      if (!primed_c) fill_q <= fill_q + BIT_W'(1);
      bit_cnt_q <= bit_cnt_d;
      bc_cnt_q  <= bc_cnt_d;
      data_out  <= data_out_d;
      valid_out <= valid_out_d;
      active    <= active_d;
    end
  end

endmodule

// File: tb/tb_stop_idle_rx.sv
// Bench for stop_idle_rx: expected bytes are queued as stimulus is issued and
// a monitor pops and compares them whenever valid_out pulses.
module tb_stop_idle_rx;

  logic       clk = 1'b0;
  logic       reset, reset1;
  logic       data_in, data_in1;
  logic [7:0] data_out, data_out1;
  logic       valid_out, valid_out1;
  logic       active, active1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int         vt0[$];
  int         vt1[$];

  stop_idle_rx #(.COMMA(8'hBC), .LOCK_COUNT(4)) dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .data_out(data_out), .valid_out(valid_out), .active(active)
  );

  stop_idle_rx #(.COMMA(8'hBC), .LOCK_COUNT(1)) dut1 (
    .clk(clk), .reset(reset1), .data_in(data_in1),
    .data_out(data_out1), .valid_out(valid_out1), .active(active1)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input bit ch, input logic b);
    if (ch) data_in1 = b;
    else    data_in  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input bit ch, input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(ch, v[i]);
  endtask

  // Monitor: every valid_out pulse must match the head of its queue
  initial forever begin
    @(negedge clk);
    if (valid_out === 1'b1) begin
      vt0.push_back(cyc);
      if (exp_q0.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dut unexpected valid_out: data_out=%0h, none expected", data_out);
      end else begin
        check("dut data_out", 32'(data_out), 32'(exp_q0.pop_front()));
      end
    end
    if (valid_out1 === 1'b1) begin
      vt1.push_back(cyc);
      if (exp_q1.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL dut1 unexpected valid_out: data_out=%0h, none expected", data_out1);
      end else begin
        check("dut1 data_out", 32'(data_out1), 32'(exp_q1.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b1; reset1 = 1'b1; data_in = 1'b0; data_in1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset data_out",   32'(data_out),   32'h00);
    check("reset valid_out",  32'(valid_out),  32'h0);
    check("reset active",     32'(active),     32'h0);
    check("reset1 data_out",  32'(data_out1),  32'h00);
    check("reset1 valid_out", 32'(valid_out1), 32'h0);
    check("reset1 active",    32'(active1),    32'h0);

    // LOCK_COUNT=1: a single comma locks, the next byte is delivered 8 cycles later
    reset1 = 1'b0;
    send_byte(1'b1, 8'hBC);
    t0 = cyc;
    check("lc1 active after one comma", 32'(active1), 32'h1);
    exp_q1.push_back(8'hA5);
    send_byte(1'b1, 8'hA5);
    @(negedge clk); #1;
    check("lc1 pulse count", 32'(vt1.size()), 32'd1);
    if (vt1.size() == 1) check("lc1 pulse latency", 32'(vt1[0] - t0), 32'd8);
    reset1 = 1'b1;

    // Basic lock: active only after the 4th comma, no pulse during lock
    reset = 1'b0;
    repeat (3) send_byte(1'b0, 8'hBC);
    check("active after 3 commas", 32'(active), 32'h0);
    send_byte(1'b0, 8'hBC);
    check("active after 4 commas", 32'(active), 32'h1);

    // Data, idle fill, data: pulses 16 cycles apart, data_out holds over idle
    vt0.delete();
    exp_q0.push_back(8'h5A);
    send_byte(1'b0, 8'h5A);
    send_byte(1'b0, 8'hBC);
    check("data_out holds over comma", 32'(data_out), 32'h5A);
    exp_q0.push_back(8'hC3);
    send_byte(1'b0, 8'hC3);
    @(negedge clk); #1;
    check("5A/C3 pulse count", 32'(vt0.size()), 32'd2);
    if (vt0.size() == 2) check("5A/C3 spacing", 32'(vt0[1] - vt0[0]), 32'd16);

    // Reset mid-byte while active: immediate clear, sticky active lost
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    reset = 1'b1;
    #1;
    check("mid-byte reset data_out",  32'(data_out),  32'h00);
    check("mid-byte reset valid_out", 32'(valid_out), 32'h0);
    check("mid-byte reset active",    32'(active),    32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("held reset active", 32'(active), 32'h0);
    reset = 1'b0;

    // Lock at a 3-bit offset, then back-to-back data
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b0);
    repeat (3) send_byte(1'b0, 8'hBC);
    check("offset active after 3 commas", 32'(active), 32'h0);
    send_byte(1'b0, 8'hBC);
    check("offset active after 4 commas", 32'(active), 32'h1);
    vt0.delete();
    exp_q0.push_back(8'h12);
    send_byte(1'b0, 8'h12);
    exp_q0.push_back(8'h34);
    send_byte(1'b0, 8'h34);
    send_byte(1'b0, 8'hBC);
    check("12/34 pulse count", 32'(vt0.size()), 32'd2);
    if (vt0.size() == 2) check("back-to-back spacing", 32'(vt0[1] - vt0[0]), 32'd8);

    // Broken lock: 77 during SYNC is dropped and a fresh 4-comma run is needed
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    send_byte(1'b0, 8'hBC);
    send_byte(1'b0, 8'hBC);
    send_byte(1'b0, 8'h77);
    check("active after broken lock", 32'(active), 32'h0);
    repeat (3) send_byte(1'b0, 8'hBC);
    check("active after 3 fresh commas", 32'(active), 32'h0);
    send_byte(1'b0, 8'hBC);
    check("active after 4 fresh commas", 32'(active), 32'h1);
    exp_q0.push_back(8'h0F);
    send_byte(1'b0, 8'h0F);
    send_byte(1'b0, 8'hBC);
    @(negedge clk); #1;

    check("dut expected bytes left",  32'(exp_q0.size()), 32'd0);
    check("dut1 expected bytes left", 32'(exp_q1.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stop_idle_rx.md
STOP_IDLE_RX -- requirements
Module: stop_idle_rx

Interface
REQ-001 Parameter COMMA, default 8'hBC: idle/comma byte value.
REQ-002 Parameter LOCK_COUNT, default 4: consecutive aligned COMMA bytes required to declare link active (range 1..15).
REQ-003 clk  input  1  serial bit clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 data_in  input  1  serial bit stream from the parallel-to-serial idle stage, MSB first.
REQ-006 data_out  output  8  last non-COMMA byte received while active.
REQ-007 valid_out  output  1  one-cycle pulse qualifying data_out.
REQ-008 active  output  1  link-active flag; asserted once lock is reached.

Function
REQ-009 The block SHALL shift data_in into an 8-bit register sr every clock: sr <= {sr[6:0], data_in}.
REQ-010 The assembled byte at any edge SHALL be {sr[6:0], data_in}.
REQ-011 The block SHALL implement three states: HUNT, SYNC, ACTIVE.
REQ-012 HUNT: bit-wise comma search; when the assembled byte equals COMMA, it SHALL go to SYNC with bit_cnt <= 0 and bc_cnt <= 1.
REQ-013 If LOCK_COUNT = 1, the HUNT comma match SHALL go directly to ACTIVE with active <= 1.
REQ-014 In SYNC and ACTIVE, bit_cnt (3 bits) SHALL increment every clock and wrap 7 -> 0; an edge with bit_cnt == 7 is a byte boundary.
REQ-015 With a comma detected at edge E, the next byte SHALL comprise the bits sampled at E+1..E+8, completing at E+8.
REQ-016 SYNC, byte boundary, byte == COMMA: bc_cnt SHALL increment; on reaching LOCK_COUNT the state SHALL become ACTIVE and active SHALL be 1 from the following cycle.
REQ-017 SYNC, byte boundary, byte != COMMA: the state SHALL return to HUNT with bc_cnt <= 0, and the byte SHALL be discarded.
REQ-018 Comma search SHALL resume at the first edge after returning to HUNT.
REQ-019 ACTIVE, byte boundary, byte != COMMA: data_out SHALL take the byte and valid_out SHALL pulse for exactly one cycle, one clock after the boundary edge.
REQ-020 ACTIVE, byte boundary, byte == COMMA: valid_out SHALL stay 0 and data_out SHALL hold its value (idle fill).
REQ-021 valid_out SHALL be 0 at all non-boundary cycles and in HUNT and SYNC.
REQ-022 active SHALL be sticky; only reset clears it.
REQ-023 Back-to-back data bytes SHALL produce valid_out pulses exactly 8 cycles apart.
REQ-024 No COMMA search SHALL occur in SYNC or ACTIVE; alignment is fixed once found.

Reset
REQ-025 While reset = 1: state = HUNT, sr = 0, bit_cnt = 0, bc_cnt = 0, data_out = 8'h00, valid_out = 0, active = 0.
REQ-026 Reset asserted mid-byte or mid-lock SHALL abort immediately with no valid_out pulse.
REQ-027 After reset deasserts, the block SHALL restart from HUNT and require a full LOCK_COUNT comma sequence.
REQ-028 Since sr = 0 after reset, a false comma SHALL NOT be detected before 8 valid bits have arrived, given COMMA != 8'h00.

Verification
REQ-029 Reset, then 4x BC serialized MSB first -> active = 1 one cycle after the 4th byte completes; no valid_out pulse.
REQ-030 Lock, then bytes 8'h5A, 8'hBC, 8'hC3 -> valid_out pulses with 8'h5A, then 8'hC3, 16 cycles apart; data_out holds 8'h5A during the BC byte.
REQ-031 3 random idle bits, then 4x BC -> comma found at a bit offset; active asserted; 8'h12 then 8'h34 received correctly.
REQ-032 BC, BC, 8'h77, BC, BC, BC, BC -> return to HUNT after 8'h77; active only after the later 4 BCs; 8'h77 never output.
REQ-033 Reset pulsed while active mid-byte -> all outputs 0 during reset; active = 0 until a fresh 4x BC sequence.
REQ-034 LOCK_COUNT = 1, single BC then 8'hA5 -> active after the first comma; valid_out with 8'hA5 8 cycles later.
